// File: rtl/timer_irq_if.sv
// Bus-side signals of the programmable timer: word-addressed register access plus the irq line.
interface timer_irq_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped down-counter timer raising irq on terminal count, in one-shot (sticky irq)
// or auto-reload (one-cycle irq pulse per period) mode.
module timer_irq #(
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus
);

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e           state_q;
  logic             ctrl_en_q;
  logic [1:0]       ctrl_mode_q;
  logic             ctrl_im_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             sticky_q;

  // Bus writes are applied after the FSM so they win over same-edge FSM updates
  // (EN clear and sticky set in StInt).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 2'd0;
      ctrl_im_q   <= 1'b0;
      preset_q    <= PRESET_RST[CNT_W-1:0];
      count_q     <= '0;
      sticky_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_en_q) state_q <= StLoad;
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!ctrl_en_q) begin
            state_q <= StIdle;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            count_q <= '0;
            state_q <= StInt;
          end
        end
        StInt: begin
          if (ctrl_mode_q == 2'd1) begin
            state_q <= StLoad;
          end else begin
            ctrl_en_q <= 1'b0;
            sticky_q  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (bus.we) begin
        if (bus.addr == AddrCtrl) begin
          ctrl_en_q   <= bus.wdata[0];
          ctrl_mode_q <= bus.wdata[2:1];
          ctrl_im_q   <= bus.wdata[3];
        end
        if (bus.addr == AddrPreset) preset_q <= bus.wdata[CNT_W-1:0];
        // Software ack: any CTRL/PRESET write clears the latched one-shot interrupt.
        if (bus.addr == AddrCtrl || bus.addr == AddrPreset) sticky_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      AddrCtrl:   bus.rdata = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
      AddrPreset: bus.rdata = 32'(preset_q);
      AddrCount:  bus.rdata = 32'(count_q);
      default:    bus.rdata = '0;
    endcase
  end

  assign bus.irq = ctrl_im_q & ((state_q == StInt) | sticky_q);

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: a vector table for one-shot/auto-reload runs plus hand-written
// sequences for masking, abort, collisions and mid-count reset.
module tb_timer_irq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  timer_irq_if bus ();

  timer_irq #(
    .CNT_W      (16),
    .PRESET_RST (32'd7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[37];

  function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic [1:0] ra, input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.raddr = ra; v.exp_rdata = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Starts and ends on a negedge; the bus access happens on the posedge in between.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [1:0] ra);
    bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.addr = ra; bus.wdata = '0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;

    // One-shot: PRESET=5 (upper bits dropped at CNT_W=16), CTRL=0x9
    vecs[0]  = mk(1, 1, 32'hFFFF_0005, 1, 32'd5, 0);
    vecs[1]  = mk(1, 0, 32'h9, 0, 32'h9, 0);
    vecs[2]  = mk(0, 0, 0, 2, 32'd0, 0);
    vecs[3]  = mk(0, 0, 0, 2, 32'd5, 0);
    vecs[4]  = mk(0, 0, 0, 2, 32'd4, 0);
    vecs[5]  = mk(0, 0, 0, 2, 32'd3, 0);
    vecs[6]  = mk(0, 0, 0, 2, 32'd2, 0);
    vecs[7]  = mk(0, 0, 0, 2, 32'd1, 0);
    vecs[8]  = mk(0, 0, 0, 2, 32'd0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 32'h8, 1);
    vecs[10] = mk(0, 0, 0, 2, 32'd0, 1);
    vecs[11] = mk(1, 0, 32'h8, 0, 32'h8, 0);
    vecs[12] = mk(0, 0, 0, 0, 32'h8, 0);
    // Auto-reload: PRESET=3, CTRL=0xB, four 5-cycle periods
    vecs[13] = mk(1, 1, 32'd3, 1, 32'd3, 0);
    vecs[14] = mk(1, 0, 32'hB, 0, 32'hB, 0);
    for (int p = 0; p < 4; p++) begin
      vecs[15 + 5*p] = mk(0, 0, 0, 2, 32'd0, 0);
      vecs[16 + 5*p] = mk(0, 0, 0, 2, 32'd3, 0);
      vecs[17 + 5*p] = mk(0, 0, 0, 2, 32'd2, 0);
      vecs[18 + 5*p] = mk(0, 0, 0, 2, 32'd1, 0);
      vecs[19 + 5*p] = mk(0, 0, 0, 2, 32'd0, 1);
    end
    vecs[35] = mk(0, 0, 0, 0, 32'hB, 0);
    vecs[36] = mk(1, 0, 32'h0, 0, 32'h0, 0);

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, 32'd7);
    rd_chk("rst_count", 2'd2, 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 37; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].raddr);
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(vecs[i].exp_irq));
    end

    // Masked one-shot: counts to INT with no irq, EN self-clears, ack leaves irq low
    step(1, 1, 32'd2, 1);
    chk("mask_preset", bus.rdata, 32'd2);
    step(1, 0, 32'h1, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 2);
      chk("mask_irq_low", 32'(bus.irq), 32'd0);
    end
    chk("mask_count_end", bus.rdata, 32'd0);
    step(0, 0, 0, 0);
    chk("mask_en_cleared", bus.rdata, 32'd0);
    chk("mask_irq_idle", 32'(bus.irq), 32'd0);
    step(1, 0, 32'h8, 0);
    chk("mask_ack_irq", 32'(bus.irq), 32'd0);

    // IM set mid-count: irq appears at terminal count and stays latched
    step(1, 0, 32'h1, 2);
    step(0, 0, 0, 2);
    step(1, 0, 32'h9, 2);
    chk("im_late_count", bus.rdata, 32'd2);
    chk("im_late_irq0", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("im_late_irq1", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("im_late_int", 32'(bus.irq), 32'd1);
    step(0, 0, 0, 0);
    chk("im_late_sticky", 32'(bus.irq), 32'd1);
    chk("im_late_ctrl", bus.rdata, 32'h8);
    step(1, 0, 32'h0, 0);
    chk("im_late_ack", 32'(bus.irq), 32'd0);

    // Abort: EN cleared as COUNT steps 5->4, COUNT then holds with no irq
    step(1, 1, 32'd6, 2);
    step(1, 0, 32'h9, 2);
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    chk("abort_count5", bus.rdata, 32'd5);
    step(1, 0, 32'h8, 2);
    chk("abort_count4", bus.rdata, 32'd4);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 2);
      chk("abort_hold", bus.rdata, 32'd4);
      chk("abort_no_irq", 32'(bus.irq), 32'd0);
    end

    // PRESET=0 behaves as 1; CTRL write on INT edge keeps written EN and clears sticky
    step(1, 1, 32'd0, 1);
    chk("p0_preset", bus.rdata, 32'd0);
    step(1, 0, 32'h9, 2);
    step(0, 0, 0, 2);
    chk("p0_load_irq", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("p0_cnt_irq", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("p0_int_irq", 32'(bus.irq), 32'd1);
    chk("p0_int_count", bus.rdata, 32'd0);
    step(1, 0, 32'h9, 0);
    chk("coll_ctrl", bus.rdata, 32'h9);
    chk("coll_irq", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    chk("coll_rerun_irq0", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("coll_rerun_int", 32'(bus.irq), 32'd1);
    step(1, 2, 32'h55, 2);
    chk("count_wr_ignored", bus.rdata, 32'd0);
    chk("count_wr_no_ack", 32'(bus.irq), 32'd1);
    step(1, 0, 32'h0, 0);
    chk("coll_ack", 32'(bus.irq), 32'd0);

    // Mode 1 at COUNT=10, then reset mid-count
    step(1, 1, 32'd10, 1);
    step(1, 0, 32'hB, 2);
    step(1, 3, 32'hFFFF_FFFF, 3);
    chk("reserved_rd", bus.rdata, 32'd0);
    step(1, 2, 32'd3, 2);
    chk("midrst_count10", bus.rdata, 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    rd_chk("midrst_ctrl", 2'd0, 32'd0);
    rd_chk("midrst_preset", 2'd1, 32'd7);
    rd_chk("midrst_count", 2'd2, 32'd0);
    chk("midrst_irq", 32'(bus.irq), 32'd0);
    step(0, 0, 0, 2);
    chk("midrst_stays_idle", bus.rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
